// File: rtl/find_global_bkt_lvl.sv
`default_nettype none
// ============================================================================
// Module      : find_global_bkt_lvl
// Description : After a local conflict, walks the learned clause, tracks the
//               highest and second-highest assignment level of its literals
//               and maps the second-highest level to its decision bin. That
//               (level, bin) pair is the global backtrack target.
// Options     : FIND_BKT_STATS_EN adds a search counter and a last-search
//               cycle count (find_cnt_o, last_cycles_o).
// Revision    : 1.0 - initial release
// ============================================================================
module find_global_bkt_lvl #(
    parameter int WIDTH_VAR     = 12,
    parameter int WIDTH_LVL     = 16,
    parameter int WIDTH_BIN_ID  = 10,
    parameter int MAX_LITS      = 16,
    parameter int WIDTH_LIT_CNT = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_find_i,
    output logic                     done_find_o,
    input  logic [WIDTH_LIT_CNT-1:0] lit_cnt_i,
    output logic [WIDTH_LIT_CNT-1:0] lit_idx_o,
    input  logic [WIDTH_VAR-1:0]     lit_var_i,
    output logic                     vs_rd_en_o,
    output logic [WIDTH_VAR-1:0]     vs_addr_o,
    input  logic [WIDTH_LVL-1:0]     vs_lvl_i,
    output logic                     lb_rd_en_o,
    output logic [WIDTH_LVL-1:0]     lb_addr_o,
    input  logic [WIDTH_BIN_ID-1:0]  lb_bin_i,
    output logic [WIDTH_LVL-1:0]     bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0]  bkt_bin_o,
    output logic                     busy_o,
    output logic                     error_o
`ifdef FIND_BKT_STATS_EN
    ,
    output logic [31:0]              find_cnt_o,
    output logic [15:0]              last_cycles_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_DRAIN   = 3'd2,
        S_LOOKUP  = 3'd3,
        S_LK_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH_LIT_CNT-1:0] cnt_q, cnt_d;
    logic [WIDTH_LIT_CNT-1:0] idx_q, idx_d;
    logic                     var_vld_q, var_vld_d;   // lit_var_i holds a valid id
    logic                     lvl_vld_q, lvl_vld_d;   // vs_lvl_i holds a valid level
    logic [WIDTH_LVL-1:0]     hi_q, hi_d;
    logic [WIDTH_LVL-1:0]     lo_q, lo_d;
    logic [WIDTH_LVL-1:0]     bkt_lvl_q, bkt_lvl_d;
    logic [WIDTH_BIN_ID-1:0]  bkt_bin_q, bkt_bin_d;
    logic                     err_q, err_d;
    logic                     done_q, done_d;

    logic                     w_start_ok;
    logic                     w_cnt_legal;

    // A start is only accepted when fully idle (done cycle of an error search counts as busy)
    assign w_start_ok  = start_find_i && (state_q == S_IDLE) && !done_q;
    assign w_cnt_legal = (lit_cnt_i != '0) && (lit_cnt_i <= WIDTH_LIT_CNT'(MAX_LITS));

    // Next-state, level tracking and result capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        bkt_lvl_d = bkt_lvl_q;
        bkt_bin_d = bkt_bin_q;
        err_d     = err_q;
        done_d    = 1'b0;
        var_vld_d = (state_q == S_SCAN);
        lvl_vld_d = var_vld_q;

        // Fold each returned level; equal-to-hi falls through to the lo test, giving lo = hi on ties
        if (lvl_vld_q) begin
            if (vs_lvl_i > hi_q) begin
                lo_d = hi_q;
                hi_d = vs_lvl_i;
            end else if (vs_lvl_i > lo_q) begin
                lo_d = vs_lvl_i;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (w_start_ok) begin
                    hi_d      = '0;
                    lo_d      = '0;
                    bkt_lvl_d = '0;
                    bkt_bin_d = '0;
                    if (w_cnt_legal) begin
                        err_d   = 1'b0;
                        cnt_d   = lit_cnt_i;
                        idx_d   = '0;
                        state_d = S_SCAN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_SCAN: begin
                if (idx_q == cnt_q - 1'b1) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Leave once the final level is on vs_lvl_i (no var id still in flight)
                if (!var_vld_q) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = S_LK_WAIT;
            end
            S_LK_WAIT: begin
                bkt_lvl_d = lo_q;
                bkt_bin_d = (lo_q == '0) ? '0 : lb_bin_i;
                done_d    = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                // Error searches pulse done one cycle after entering DONE
                done_d  = err_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            var_vld_q <= 1'b0;
            lvl_vld_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            bkt_lvl_q <= '0;
            bkt_bin_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            var_vld_q <= var_vld_d;
            lvl_vld_q <= lvl_vld_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            bkt_lvl_q <= bkt_lvl_d;
            bkt_bin_q <= bkt_bin_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign lit_idx_o   = idx_q;
    assign vs_rd_en_o  = var_vld_q;
    assign vs_addr_o   = lit_var_i;
    assign lb_rd_en_o  = (state_q == S_LOOKUP);
    assign lb_addr_o   = lb_rd_en_o ? lo_q : '0;
    assign bkt_lvl_o   = bkt_lvl_q;
    assign bkt_bin_o   = bkt_bin_q;
    assign error_o     = err_q;
    assign done_find_o = done_q;
    assign busy_o      = (state_q != S_IDLE) || done_q;

`ifdef FIND_BKT_STATS_EN
    logic [31:0] find_cnt_q, find_cnt_d;
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] last_q, last_d;

    // Cycle counter runs from the accepted start; both counters saturate
    always_comb begin
        find_cnt_d = find_cnt_q;
        cyc_d      = cyc_q;
        last_d     = last_q;
        if (w_start_ok) begin
            cyc_d = 16'd1;
        end else if (busy_o && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end
        if (done_q) begin
            last_d = cyc_q;
            if (find_cnt_q != 32'hFFFF_FFFF) begin
                find_cnt_d = find_cnt_q + 32'd1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            find_cnt_q <= '0;
            cyc_q      <= '0;
            last_q     <= '0;
        end else begin
            find_cnt_q <= find_cnt_d;
            cyc_q      <= cyc_d;
            last_q     <= last_d;
        end
    end

    assign find_cnt_o    = find_cnt_q;
    assign last_cycles_o = last_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_find_global_bkt_lvl.sv
`default_nettype none
// ============================================================================
// Module      : tb_find_global_bkt_lvl
// Description : Scoreboard bench for find_global_bkt_lvl with behavioural
//               clause buffer, var-state RAM and level-to-bin table.
// Options     : FIND_BKT_STATS_EN also checks the statistics ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_find_global_bkt_lvl;

    logic        clk;
    logic        rst;
    logic        start_find_i;
    logic        done_find_o;
    logic [4:0]  lit_cnt_i;
    logic [4:0]  lit_idx_o;
    logic [11:0] lit_var_i;
    logic        vs_rd_en_o;
    logic [11:0] vs_addr_o;
    logic [15:0] vs_lvl_i;
    logic        lb_rd_en_o;
    logic [15:0] lb_addr_o;
    logic [9:0]  lb_bin_i;
    logic [15:0] bkt_lvl_o;
    logic [9:0]  bkt_bin_o;
    logic        busy_o;
    logic        error_o;
`ifdef FIND_BKT_STATS_EN
    logic [31:0] find_cnt_o;
    logic [15:0] last_cycles_o;
`endif

    find_global_bkt_lvl dut (
        .clk          (clk),
        .rst          (rst),
        .start_find_i (start_find_i),
        .done_find_o  (done_find_o),
        .lit_cnt_i    (lit_cnt_i),
        .lit_idx_o    (lit_idx_o),
        .lit_var_i    (lit_var_i),
        .vs_rd_en_o   (vs_rd_en_o),
        .vs_addr_o    (vs_addr_o),
        .vs_lvl_i     (vs_lvl_i),
        .lb_rd_en_o   (lb_rd_en_o),
        .lb_addr_o    (lb_addr_o),
        .lb_bin_i     (lb_bin_i),
        .bkt_lvl_o    (bkt_lvl_o),
        .bkt_bin_o    (bkt_bin_o),
        .busy_o       (busy_o),
        .error_o      (error_o)
`ifdef FIND_BKT_STATS_EN
        ,
        .find_cnt_o    (find_cnt_o),
        .last_cycles_o (last_cycles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] lvl;
        logic [9:0]  bin;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          vs_rd_cnt = 0;
    int          lb_rd_cnt = 0;
    int          exp_dones = 0;
    int          last_lat = 0;

    logic [11:0] clause [0:31];
    logic [15:0] vs_mem [0:4095];
    logic [9:0]  lb_mem [0:65535];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory models: each read returns one cycle after its address
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        lit_var_i <= clause[lit_idx_o];
        if (vs_rd_en_o) vs_lvl_i <= vs_mem[vs_addr_o];
        if (lb_rd_en_o) lb_bin_i <= lb_mem[lb_addr_o];
    end

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (vs_rd_en_o) vs_rd_cnt++;
        if (lb_rd_en_o) lb_rd_cnt++;
        if (!rst && done_find_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("bkt_lvl", bkt_lvl_o, e.lvl);
                chk("bkt_bin", bkt_bin_o, e.bin);
                chk("error", error_o, e.err);
                chk("latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic load(input int idx, input logic [11:0] v, input logic [15:0] l);
        clause[idx] = v;
        vs_mem[v]   = l;
    endtask

    task automatic run_case(input int cnt, input logic [15:0] e_lvl, input logic [9:0] e_bin,
                            input logic e_err, input int e_lat, input bit dup);
        exp_t e;
        @(negedge clk);
        start_find_i = 1'b1;
        lit_cnt_i    = 5'(cnt);
        e.lvl = e_lvl; e.bin = e_bin; e.err = e_err; e.lat = e_lat; e.t0 = cyc;
        sb_q.push_back(e);
        exp_dones++;
        last_lat = e_lat;
        @(negedge clk);
        start_find_i = 1'b0;
        if (dup) begin
            @(negedge clk);
            start_find_i = 1'b1;
            @(negedge clk);
            start_find_i = 1'b0;
        end
        for (int k = 0; k < 60 && sb_q.size() != 0; k++) @(negedge clk);
        if (sb_q.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int vs0, lb0;
        for (int i = 0; i < 32; i++) clause[i] = '0;
        for (int i = 0; i < 4096; i++) vs_mem[i] = '0;
        for (int i = 0; i < 65536; i++) lb_mem[i] = '0;
        rst = 1'b1; start_find_i = 1'b0; lit_cnt_i = '0;
        lit_var_i = '0; vs_lvl_i = '0; lb_bin_i = '0;
        lb_mem[5] = 10'd2; lb_mem[4] = 10'd6; lb_mem[0] = 10'd7;
        lb_mem[15] = 10'd3; lb_mem[9] = 10'd4; lb_mem[6] = 10'd5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_done", done_find_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_bkt_lvl", bkt_lvl_o, 0);
        chk("rst_bkt_bin", bkt_bin_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_rd_en", {vs_rd_en_o, lb_rd_en_o}, 0);
        chk("rst_lit_idx", lit_idx_o, 0);

        // Case 1 with an ignored second start during SCAN
        load(0, 12'd100, 16'd3); load(1, 12'd101, 16'd7); load(2, 12'd102, 16'd5);
        run_case(3, 16'd5, 10'd2, 1'b0, 8, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_bkt_lvl", bkt_lvl_o, 5);
        chk("hold_bkt_bin", bkt_bin_o, 2);

        // Tie at the highest level
        load(0, 12'd200, 16'd4); load(1, 12'd201, 16'd4); load(2, 12'd202, 16'd1);
        run_case(3, 16'd4, 10'd6, 1'b0, 8, 1'b0);

        // Unit clause: lo stays 0, bin forced 0 even though lb[0] is non-zero
        load(0, 12'd300, 16'd9);
        run_case(1, 16'd0, 10'd0, 1'b0, 6, 1'b0);

        // Illegal counts issue no memory reads
        vs0 = vs_rd_cnt; lb0 = lb_rd_cnt;
        run_case(0, 16'd0, 10'd0, 1'b1, 2, 1'b0);
        run_case(17, 16'd0, 10'd0, 1'b1, 2, 1'b0);
        chk("illegal_vs_rd", vs_rd_cnt - vs0, 0);
        chk("illegal_lb_rd", lb_rd_cnt - lb0, 0);

        // Maximum clause length, levels 1..16
        for (int i = 0; i < 16; i++) load(i, 12'(400 + i), 16'(i + 1));
        run_case(16, 16'd15, 10'd3, 1'b0, 21, 1'b0);

        // Two literals at the top level after a lower one
        load(0, 12'd500, 16'd2); load(1, 12'd501, 16'd9);
        load(2, 12'd502, 16'd9); load(3, 12'd503, 16'd3);
        run_case(4, 16'd9, 10'd4, 1'b0, 9, 1'b0);

        // Second-highest arrives after the highest
        load(0, 12'd600, 16'd8); load(1, 12'd601, 16'd2);
        load(2, 12'd602, 16'd6); load(3, 12'd603, 16'd1);
        run_case(4, 16'd6, 10'd5, 1'b0, 9, 1'b0);

        // Reset in the middle of a search
        load(0, 12'd100, 16'd3); load(1, 12'd101, 16'd7); load(2, 12'd102, 16'd5);
        @(negedge clk);
        start_find_i = 1'b1;
        lit_cnt_i    = 5'd3;
        @(negedge clk);
        start_find_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_outs", {done_find_o, error_o, vs_rd_en_o, lb_rd_en_o}, 0);
        chk("midrst_lit_idx", lit_idx_o, 0);
        chk("midrst_bkt", {bkt_lvl_o, bkt_bin_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_dones = 0;
        repeat (20) @(negedge clk);

        // Back-to-back cases 1, 2, 3
        run_case(3, 16'd5, 10'd2, 1'b0, 8, 1'b0);
        load(0, 12'd200, 16'd4); load(1, 12'd201, 16'd4); load(2, 12'd202, 16'd1);
        run_case(3, 16'd4, 10'd6, 1'b0, 8, 1'b0);
        load(0, 12'd300, 16'd9);
        run_case(1, 16'd0, 10'd0, 1'b0, 6, 1'b0);
`ifdef FIND_BKT_STATS_EN
        chk("find_cnt", find_cnt_o, exp_dones);
        chk("last_cycles", last_cycles_o, last_lat);
`endif
        chk("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
